// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame-format defaults and
// a counter-width helper used by the receive and transmit datapaths.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: a DIV-clock counter that pulses o_tick on wrap.
// i_clr holds the phase at zero so the first tick lands DIV clocks after release.
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int DW = cnt_width(DIV);

    logic [DW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == DW'(DIV - 1));
    assign o_tick = i_en & w_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB-first, oversampled with mid-bit sampling and a
// valid/ready byte output. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV        = 2,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [OS_W-1:0]      r_os_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_tick;
    logic                 w_cnt_en;
    logic                 w_os_last;
    logic                 w_byte_ok;

    // NOTE: non-blocking assignments keep the two stages as distinct flops;
    // blocking ones would collapse the synchronizer into a single register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s    = r_sync2;
    assign w_cnt_en  = (r_state != IDLE) && (r_state != WAIT_HIGH);
    assign w_os_last = (r_os_cnt == OS_LAST);

    uart_os_tick #(
        .DIV (DIV)
    ) u_os_tick (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_cnt_en),
        .i_clr  (!w_cnt_en),
        .o_tick (w_tick)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;

    assign w_byte_ok  = !r_par_bad;
    assign parity_err = r_parity_err;
`else
    assign w_byte_ok  = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: error strobes default low every clock; the case below
            // raises them for exactly the one cycle they apply.
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
            if (w_tick) begin
                r_os_cnt <= w_os_last ? '0 : r_os_cnt + OS_W'(1);
            end

            unique case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_os_cnt <= '0;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_tick && (r_os_cnt == OS_MID)) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_os_cnt  <= '0;
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_par_bad <= 1'b0;
`endif
                            r_state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_tick && w_os_last) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick && w_os_last) begin
                        r_par_bad    <= (w_rx_s != ^r_shift);
                        r_parity_err <= (w_rx_s != ^r_shift);
                        r_state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tick && w_os_last) begin
                        if (!w_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_HIGH;
                        end else begin
                            r_state <= IDLE;
                            // A byte accepted this very clock frees the slot.
                            if (w_byte_ok) begin
                                if (!r_valid || rx_ready) begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: stimulus pushes expected bytes and
// error counts from a frame-level model; a monitor pops on each transfer.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DIV       = 2;
    localparam int OS        = 16;
    localparam int DATA_BITS = 8;
    localparam int BIT_CLKS  = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Start edge to rx_valid: 2 sync clocks, 1 edge-detect clock, half a bit
    // to the start centre, then whole bits to the stop centre, +1 to register.
    localparam int EXP_LAT = 3 + BIT_CLKS / 2 + (DATA_BITS + PAR_BITS + 1) * BIT_CLKS - 1 + 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 rx_in = 1'b1;
    logic                 rx_ready = 1'b1;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 parity_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int n_ferr = 0, n_ovr = 0, n_perr = 0;
    int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .DIV        (DIV),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DATA_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts error pulses and checks every handshake transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err)  n_ferr++;
            if (overrun)    n_ovr++;
            if (parity_err) n_perr++;
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rx_valid;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_byte: got %0h, expected no byte (cycle %0d)", rx_data, cyc);
                end else begin
                    check("rx_data", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        clocks(n);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        clocks(BIT_CLKS);
    endtask

    // Drives start, data LSB first, optional parity and the stop bit; the line
    // is left at the stop level so callers choose what follows.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
`endif
        send_bit(stop_b);
    endtask

    // Frame-level reference: what a consumer that is always ready should see.
    task automatic expect_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        logic good;
        good = stop_b;
`ifdef UART_RX_PARITY_EN
        if (par_b != ^d) begin
            exp_perr++;
            good = 1'b0;
        end
`endif
        if (!stop_b) exp_ferr++;
        if (good) exp_q.push_back(d);
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_frame_err_count"}, n_ferr, exp_ferr);
        check({tag, "_overrun_count"}, n_ovr, exp_ovr);
        check({tag, "_parity_err_count"}, n_perr, exp_perr);
    endtask

    initial begin
        logic [7:0] d;
        logic       stop_b;
        logic       par_b;
        int         t0;

        // Reset values.
        clocks(4);
        check("reset_rx_data", {24'b0, rx_data}, 32'h0);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        reset = 1'b1;
        idle(20);

        // 0xA5 with exact latency from the start edge.
        expect_frame(8'hA5, 1'b1, ^8'hA5);
        t0 = cyc;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(10);
        check("a5_latency", rise_cyc - t0, EXP_LAT);
        check("a5_drained", exp_q.size(), 0);
        check_errs("a5");

        // Short low glitch must be rejected as a false start.
        rx_in = 1'b0;
        clocks(10);
        idle(400);
        check("glitch_rx_valid", rx_valid, 1'b0);
        check_errs("glitch");

        // Bad stop bit followed by a held-low break.
        expect_frame(8'h3C, 1'b0, ^8'h3C);
        send_frame(8'h3C, 1'b0, ^8'h3C);
        clocks(100);
        check("break_frame_err_count", n_ferr, exp_ferr);
        idle(400);
        check("break_rx_valid", rx_valid, 1'b0);
        check_errs("break");

        // Randomized frames with random gaps and occasional bad stop bits.
        for (int k = 0; k < 12; k++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 7) != 0);
            par_b  = ^d;
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 7) == 0) par_b = ~par_b;
`endif
            expect_frame(d, stop_b, par_b);
            send_frame(d, stop_b, par_b);
            idle(stop_b ? $urandom_range(0, 40) : $urandom_range(8, 40));
        end
        idle(40);
        check("random_drained", exp_q.size(), 0);
        check_errs("random");

        // Overrun: consumer stalls across two back-to-back frames.
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, ^8'h11);
        exp_ovr++;
        send_frame(8'h22, 1'b1, ^8'h22);
        idle(20);
        check("ovr_valid_held", rx_valid, 1'b1);
        check("ovr_data_held", {24'b0, rx_data}, 32'h11);
        check_errs("ovr");
        rx_ready = 1'b1;
        clocks(1);
        rx_ready = 1'b0;
        @(negedge clk);
        check("ovr_valid_drop", rx_valid, 1'b0);
        check("ovr_drained", exp_q.size(), 0);

        // Accept on the very clock the next frame loads: no overrun.
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, ^8'h33);
        idle(20);
        exp_q.push_back(8'h44);
        fork
            send_frame(8'h44, 1'b1, ^8'h44);
            begin
                repeat (EXP_LAT - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(20);
        check("simul_valid_held", rx_valid, 1'b1);
        check("simul_pending", exp_q.size(), 1);
        check_errs("simul");
        rx_ready = 1'b1;
        idle(10);
        check("simul_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of the 4th data bit.
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1, ^8'h77);
        idle(10);
        check("pre_reset_valid", rx_valid, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx_in = 1'b0;
        clocks(BIT_CLKS / 2);
        #3 reset = 1'b0;
        #1;
        check("midreset_rx_data", {24'b0, rx_data}, 32'h0);
        check("midreset_rx_valid", rx_valid, 1'b0);
        check("midreset_frame_err", frame_err, 1'b0);
        check("midreset_overrun", overrun, 1'b0);
        check("midreset_parity_err", parity_err, 1'b0);
        rx_in = 1'b1;
        clocks(5);
        reset = 1'b1;
        rx_ready = 1'b1;
        idle(20);
        expect_frame(8'h5A, 1'b1, ^8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(20);
        check("post_reset_drained", exp_q.size(), 0);
        check_errs("reset");

`ifdef UART_RX_PARITY_EN
        // Wrong then correct even-parity bit on 0x07.
        expect_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(40);
        check("par_bad_rx_valid", rx_valid, 1'b0);
        expect_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(40);
        check("par_good_drained", exp_q.size(), 0);
        check_errs("parity");
`endif

        idle(100);
        check("final_drained", exp_q.size(), 0);
        check_errs("final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
